// File: rtl/seq_pattern_pkg.sv
// Shared types and constants for the serial frame transmitter.
package seq_pattern_pkg;

    typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} tx_state_t;

    localparam logic [3:0] SEQ_PRE_1010 = 4'b1010;
    localparam int         SEQ_PRE_LEN  = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in/serial-out shift register, MSB first. o_msb is the bit that
// leaves on this edge, so a load and first shift may share one edge.
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_din,
    output logic         o_msb
);
    logic [W-1:0] r_sh;

    always_ff @(posedge clk) begin
        if (!rst)
            r_sh <= '0;
        else if (i_load && i_shift)
            r_sh <= i_din << 1;
        else if (i_load)
            r_sh <= i_din;
        else if (i_shift)
            r_sh <= r_sh << 1;
    end

    assign o_msb = i_load ? i_din[W-1] : r_sh[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, idle gap.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_pattern_tx
    import seq_pattern_pkg::*;
#(
    parameter int                 DATA_W  = 8,
    parameter int                 PRE_LEN = SEQ_PRE_LEN,
    parameter logic [PRE_LEN-1:0] PRE_PAT = SEQ_PRE_1010,
    parameter int                 GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              x_out,
    output logic              x_valid,
    output logic              busy,
    output logic              frame_done
);
    localparam int CNT_W = $clog2(max3(PRE_LEN, DATA_W, GAP_CYC) + 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_PRE  = CNT_W'(PRE_LEN);
    localparam logic [CNT_W-1:0] C_DATA = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] C_GAP  = CNT_W'(GAP_CYC);

    tx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_x_out;
    logic             r_x_valid;
    logic             r_done;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    logic             r_par;
`endif

    tx_state_t        w_nstate;
    logic [CNT_W-1:0] w_ncnt;
    logic [CNT_W-1:0] w_dec;
    logic             w_last;
    logic             w_acc;
    logic             w_pre_msb;
    logic             w_dat_msb;

    assign w_acc  = in_valid && (r_state == IDLE);
    assign w_last = (r_cnt == C_ONE);
    assign w_dec  = r_cnt - C_ONE;

    // Counter reloads on every state entry and the state moves on when it reads 1.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        case (r_state)
            IDLE: if (w_acc) begin
                w_nstate = PRE;
                w_ncnt   = C_PRE;
            end
            PRE: if (w_last) begin
                w_nstate = DATA;
                w_ncnt   = C_DATA;
            end else begin
                w_ncnt   = w_dec;
            end
            DATA: if (w_last) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                w_nstate = PAR;
                w_ncnt   = C_ONE;
`else
                w_nstate = GAP;
                w_ncnt   = C_GAP;
`endif
            end else begin
                w_ncnt   = w_dec;
            end
            PAR: begin
                w_nstate = GAP;
                w_ncnt   = C_GAP;
            end
            GAP: if (w_last) begin
                w_nstate = IDLE;
                w_ncnt   = '0;
            end else begin
                w_ncnt   = w_dec;
            end
            default: begin
                w_nstate = IDLE;
                w_ncnt   = '0;
            end
        endcase
    end

    piso_shift #(.W(PRE_LEN)) u_pre (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_acc),
        .i_shift (w_nstate == PRE),
        .i_din   (PRE_PAT),
        .o_msb   (w_pre_msb)
    );

    piso_shift #(.W(DATA_W)) u_dat (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_acc),
        .i_shift (w_nstate == DATA),
        .i_din   (in_data),
        .o_msb   (w_dat_msb)
    );

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_x_out   <= 1'b0;
            r_x_valid <= 1'b0;
            r_done    <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state   <= w_nstate;
            r_cnt     <= w_ncnt;
            r_x_valid <= (w_nstate == PRE) || (w_nstate == DATA) || (w_nstate == PAR);
            r_done    <= (w_nstate == GAP) && (w_ncnt == C_ONE);
            case (w_nstate)
                PRE:     r_x_out <= w_pre_msb;
                DATA:    r_x_out <= w_dat_msb;
`ifdef SEQ_PATTERN_TX_PARITY_EN
                PAR:     r_x_out <= r_par;
`endif
                default: r_x_out <= 1'b0;
            endcase
`ifdef SEQ_PATTERN_TX_PARITY_EN
            if (w_acc)
                r_par <= ^in_data;
`endif
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign x_out      = r_x_out;
    assign x_valid    = r_x_valid;
    assign frame_done = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: vector table, directed corner sequences and a
// random run checked against a per-frame queue model.
module tb_seq_pattern_tx;
    localparam int         DATA_W  = 8;
    localparam int         PRE_LEN = 4;
    localparam logic [3:0] PRE_PAT = 4'b1010;
    localparam int         GAP_CYC = 2;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam int         PAR_CYC = 1;
`else
    localparam int         PAR_CYC = 0;
`endif
    localparam int         FL = PRE_LEN + DATA_W + PAR_CYC + GAP_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, x_out, x_valid, busy, frame_done;

    always #5 clk = ~clk;

    seq_pattern_tx #(
        .DATA_W  (DATA_W),
        .PRE_LEN (PRE_LEN),
        .PRE_PAT (PRE_PAT),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct { logic x; logic v; logic d; } beat_t;
    beat_t mq[$];

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] d;
        logic       ex, ev, ed, eb, er;
    } vec_t;
    vec_t tbl[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: the frame is a list of per-cycle output beats; one is consumed per clock.
    function automatic void model_step();
        if (!rst) begin
            mq.delete();
        end else if (mq.size() == 0) begin
            if (in_valid) begin
                for (int i = PRE_LEN - 1; i >= 0; i--) mq.push_back('{PRE_PAT[i], 1'b1, 1'b0});
                for (int i = DATA_W - 1; i >= 0; i--) mq.push_back('{in_data[i], 1'b1, 1'b0});
`ifdef SEQ_PATTERN_TX_PARITY_EN
                mq.push_back('{^in_data, 1'b1, 1'b0});
`endif
                for (int g = 0; g < GAP_CYC; g++) mq.push_back('{1'b0, 1'b0, (g == GAP_CYC - 1)});
            end
        end else begin
            void'(mq.pop_front());
        end
    endfunction

    task automatic tick();
        logic ex, ev, ed, eb, er;
        model_step();
        @(posedge clk);
        #1;
        if (mq.size() != 0) begin
            ex = mq[0].x; ev = mq[0].v; ed = mq[0].d; eb = 1'b1; er = 1'b0;
        end else begin
            ex = 1'b0; ev = 1'b0; ed = 1'b0; eb = 1'b0; er = 1'b1;
        end
        chk("model_x_out", x_out, ex);
        chk("model_x_valid", x_valid, ev);
        chk("model_frame_done", frame_done, ed);
        chk("model_busy", busy, eb);
        chk("model_in_ready", in_ready, er);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a5_bits;
        vec_t        r;
        int          t0, t1, starts, vcnt, rdy_hi, dones;
        logic        pb;

        // ---- vector table: reset with in_valid high, then one 8'hA5 frame
        a5_bits = 12'b1010_1010_0101;
        for (int k = 0; k < 2; k++) tbl.push_back('{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        for (int k = 1; k <= FL + 1; k++) begin
            r.rst = 1'b1; r.vld = (k == 1); r.d = 8'hA5;
            r.eb = (k <= FL); r.er = (k > FL); r.ed = (k == FL);
            if (k <= 12) begin
                r.ex = a5_bits[12 - k]; r.ev = 1'b1;
            end else if (PAR_CYC == 1 && k == 13) begin
                r.ex = 1'b0; r.ev = 1'b1;
            end else begin
                r.ex = 1'b0; r.ev = 1'b0;
            end
            tbl.push_back(r);
        end
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; in_valid = tbl[i].vld; in_data = tbl[i].d;
            tick();
            chk($sformatf("tbl_x_out[%0d]", i), x_out, tbl[i].ex);
            chk($sformatf("tbl_x_valid[%0d]", i), x_valid, tbl[i].ev);
            chk($sformatf("tbl_frame_done[%0d]", i), frame_done, tbl[i].ed);
            chk($sformatf("tbl_busy[%0d]", i), busy, tbl[i].eb);
            chk($sformatf("tbl_in_ready[%0d]", i), in_ready, tbl[i].er);
        end

        // ---- back-to-back with in_valid held high
        in_valid = 1'b1; in_data = 8'h3C;
        pb = busy; t0 = -1; t1 = -1; starts = 0;
        for (int i = 0; i < 2 * (FL + 1); i++) begin
            tick();
            if (busy && !pb) begin
                starts++;
                if (t0 < 0) t0 = i; else if (t1 < 0) t1 = i;
            end
            pb = busy;
            if (i == 0) in_data = 8'hC3;
            if (starts == 2) in_valid = 1'b0;
        end
        chk("b2b_starts", starts, 2);
        chk("b2b_period", t1 - t0, FL + 1);
        for (int i = 0; i < 4; i++) tick();

        // ---- offer while busy is ignored
        in_valid = 1'b1; in_data = 8'h00;
        tick();
        in_valid = 1'b0;
        vcnt = (x_valid === 1'b1) ? 1 : 0;
        rdy_hi = (in_ready === 1'b1) ? 1 : 0;
        for (int c = 2; c <= FL + 4; c++) begin
            if (c == 6) in_valid = 1'b0;
            tick();
            if (c == 5) begin in_valid = 1'b1; in_data = 8'hFF; end
            if (x_valid === 1'b1) vcnt++;
            if (c <= FL && in_ready !== 1'b0) rdy_hi++;
        end
        chk("ignore_valid_bits", vcnt, PRE_LEN + DATA_W + PAR_CYC);
        chk("ignore_ready_low", rdy_hi, 0);
        chk("ignore_no_second_frame", busy, 1'b0);

        // ---- reset in the middle of a frame
        in_valid = 1'b1; in_data = 8'h5A;
        dones = 0;
        tick();
        in_valid = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            tick();
            if (frame_done === 1'b1) dones++;
        end
        rst = 1'b0;
        tick();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", in_ready, 1'b1);
        chk("midrst_x_valid", x_valid, 1'b0);
        chk("midrst_x_out", x_out, 1'b0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (frame_done === 1'b1) dones++;
        end
        chk("midrst_no_done", dones, 0);
        in_valid = 1'b1; in_data = 8'h96;
        tick();
        in_valid = 1'b0;
        vcnt = 1;
        for (int c = 2; c <= FL + 1; c++) begin
            tick();
            if (frame_done === 1'b1) dones++;
            if (x_valid === 1'b1) vcnt++;
        end
        chk("postrst_done_count", dones, 1);
        chk("postrst_valid_bits", vcnt, PRE_LEN + DATA_W + PAR_CYC);

        // ---- parity slot with an odd-weight word
        in_valid = 1'b1; in_data = 8'h01;
        tick();
        in_valid = 1'b0;
        for (int c = 2; c <= FL + 1; c++) begin
            tick();
            if (c == PRE_LEN + DATA_W + 1) begin
                chk("slot13_x_out", x_out, (PAR_CYC == 1) ? 1'b1 : 1'b0);
                chk("slot13_x_valid", x_valid, (PAR_CYC == 1) ? 1'b1 : 1'b0);
            end
        end

        // ---- random traffic against the model
        for (int i = 0; i < 800; i++) begin
            rst      = ($urandom_range(0, 59) != 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_data  = 8'($urandom);
            tick();
        end
        rst = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < FL + 2; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
